// File: rtl/demux_1x4_stream_pkg.sv
// demux_1x4_stream_pkg: shared constants and channel state type for the 1-to-4 stream demux.
package demux_1x4_stream_pkg;
    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;
endpackage

// File: rtl/demux_chan_reg.sv
// demux_chan_reg: one-entry holding register with valid/ready handshake.
// DEMUX_COUNT_EN adds a wrapping per-channel drain counter.
module demux_chan_reg
    import demux_1x4_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);
    chan_state_e      r_state;
    logic [WIDTH-1:0] r_data;
    // a load in the same cycle as a drain keeps the channel full with the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else if (load) begin
            r_state <= FULL;
            r_data  <= load_data;
        end else if (ready) begin
            r_state <= EMPTY;
        end
    end
    assign valid = (r_state == FULL);
    assign data  = r_data;
`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (valid && ready) r_cnt <= r_cnt + 1'b1;
    end
    assign cnt = r_cnt;
`endif
endmodule

// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: registered 1-to-4 stream demultiplexer with per-channel valid/ready.
// DEMUX_COUNT_EN exposes per-channel drain counters on cnt_flat.
module demux_1x4_stream
    import demux_1x4_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data0,
    output logic [WIDTH-1:0]  out_data1,
    output logic [WIDTH-1:0]  out_data2,
    output logic [WIDTH-1:0]  out_data3,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] cnt_flat
`endif
);
    logic [NUM_CH-1:0] w_load;
    logic [WIDTH-1:0]  w_data [NUM_CH];
    // only the selected channel gates acceptance, so backpressure is one mux level deep
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_load[k] = in_valid & in_ready & (in_sel == SEL_W'(k));
        demux_chan_reg #(
            .WIDTH(WIDTH)
`ifdef DEMUX_COUNT_EN
            ,
            .CNT_W(CNT_W)
`endif
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (w_load[k]),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (w_data[k])
`ifdef DEMUX_COUNT_EN
            ,
            .cnt      (cnt_flat[k*CNT_W +: CNT_W])
`endif
        );
    end
    assign out_data0 = w_data[0];
    assign out_data1 = w_data[1];
    assign out_data2 = w_data[2];
    assign out_data3 = w_data[3];
endmodule
